// File: rtl/alu_exec.sv
// alu_exec: multi-cycle ALU execute stage (logic ops in one cycle, MUL/DIV iterative); ALU_DIV_EN builds the divider
module alu_exec #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_outA,
    input  logic [WIDTH-1:0] data_outB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             err
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   ex_res;
    logic               ex_c;
    logic               ex_v;
    logic               ex_e;
    logic [WIDTH:0]     mul_s;
    logic [2*WIDTH-1:0] acc_nx;
    logic               iter_go;
    logic [WIDTH-1:0]   acc_init;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_r;
    logic [WIDTH:0]     div_d;
`endif

    // single-cycle result and flags from the latched operands
    always_comb begin
        add_s  = {1'b0, a} + {1'b0, b};
        sub_s  = {1'b0, a} - {1'b0, b};
        ex_res = '0;
        ex_c   = 1'b0;
        ex_v   = 1'b0;
        ex_e   = 1'b0;
        case (op_q)
            OP_ADD: begin
                ex_res = add_s[WIDTH-1:0];
                ex_c   = add_s[WIDTH];
                ex_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ex_res = sub_s[WIDTH-1:0];
                ex_c   = sub_s[WIDTH];
                ex_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: ex_res = a & b;
            OP_OR:  ex_res = a | b;
            OP_XOR: ex_res = a ^ b;
            OP_SHL: begin
                ex_res = {a[WIDTH-2:0], 1'b0};
                ex_c   = a[WIDTH-1];
            end
            OP_MUL: ex_res = '0;
            default: begin
`ifdef ALU_DIV_EN
                ex_res = '1;
`else
                ex_res = '0;
`endif
                ex_e   = 1'b1;
            end
        endcase
    end

    // one shift/add (MUL) or shift/subtract (DIV) step; acc holds {high/remainder, low/quotient}
    always_comb begin
        mul_s  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
        acc_nx = {mul_s, acc[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_r  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_d  = div_r - {1'b0, b};
        if (op_q != OP_MUL)
            acc_nx = div_d[WIDTH] ? {div_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        iter_go  = (op == OP_MUL) || (op != OP_MUL && op[2:1] == 2'b11 && |data_outB);
        acc_init = (op == OP_MUL) ? data_outB : data_outA;
`else
        iter_go  = (op == OP_MUL);
        acc_init = data_outB;
`endif
    end

    // control FSM with registered outputs; results only change on the edge that raises done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            a           <= '0;
            b           <= '0;
            acc         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_result <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    a     <= data_outA;
                    b     <= data_outB;
                    acc   <= {{WIDTH{1'b0}}, acc_init};
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= iter_go ? ITER : EXEC;
                end
                EXEC: begin
                    data_result <= ex_res;
                    carry       <= ex_c;
                    overflow    <= ex_v;
                    err         <= ex_e;
                    zero        <= (ex_res == '0);
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                ITER: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        data_result <= acc_nx[WIDTH-1:0];
                        carry       <= 1'b0;
                        overflow    <= (op_q == OP_MUL) && (|acc_nx[2*WIDTH-1:WIDTH]);
                        err         <= 1'b0;
                        zero        <= (acc_nx[WIDTH-1:0] == '0);
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Multi-cycle execute stage of the 4-bit ALU datapath.
- Consumes the operand pair held by the save stage (data_outA/data_outB), plus an opcode and a start strobe.
- Produces a registered result with a single-cycle done pulse; the save stage writes that result back into A or B.
- Single-cycle logic ops and iterative multiply/divide share one handshake.

Parameters:
- WIDTH, 4, operand/result width in bits; the iteration count for MUL/DIV equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- op  input  3  opcode, latched with start
- data_outA  input  WIDTH  operand A, latched with start
- data_outB  input  WIDTH  operand B, latched with start
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse when data_result and the flags update
- data_result  output  WIDTH  registered result; holds until the next done
- carry  output  1  carry/borrow/shift-out flag
- zero  output  1  data_result == 0
- overflow  output  1  signed overflow (ADD/SUB) or product truncation (MUL)
- err  output  1  divide-by-zero or unsupported op

Behaviour:
Interface fixes:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset:
- All outputs are 0; state is IDLE.
- Internal operand, accumulator and counter registers are 0.
- Reset asserted mid-operation aborts immediately; no done is issued.

Opcodes:
- 000 ADD: result = A+B; carry = carry-out; overflow = signed overflow.
- 001 SUB: result = A-B; carry = borrow (A<B unsigned); overflow = signed overflow.
- 010 AND, 011 OR, 100 XOR: carry = 0, overflow = 0.
- 101 SHL: result = A<<1; carry = A[WIDTH-1].
- 110 MUL: unsigned shift-add over a 2*WIDTH product.
  - result = low WIDTH bits.
  - overflow = 1 when the high half is nonzero.
- 111 DIV: unsigned restoring division.
  - result = quotient.
  - B == 0: result = all ones, err = 1, no iteration.
- zero is always derived from the new result.
- err = 0 for every op except those noted.

State machine: IDLE, EXEC, ITER, DONE.
- IDLE: on start=1 at edge k, latch op, A and B; go to ITER for MUL, or for DIV with B≠0; otherwise go to EXEC. busy rises.
- EXEC: compute; register result and flags at edge k+1; go to DONE.
- ITER: a counter runs WIDTH iterations (one shift/add or shift/subtract per cycle). Result and flags are registered at edge k+WIDTH; go to DONE.
- DONE: done=1 for exactly that one cycle, busy=0; return to IDLE at the next edge.
- Latency from the start edge to the done pulse: 1 cycle for single-cycle ops, WIDTH cycles for iterative ops.

Handshake rules:
- start while busy or in DONE is ignored; it is neither queued nor able to corrupt the latched operands.
- start held high re-triggers only once back in IDLE.
- Operand inputs may change freely after the start edge.
- data_result and the flags change only on the edge that raises done.

Optional Feature:
Macro ALU_DIV_EN.
- Defined: op 111 performs restoring division as above.
- Undefined:
  - Divider logic is not built.
  - op 111 takes the EXEC path: done at single-cycle latency, data_result = 0, zero = 1, err = 1.
  - All other ops are unchanged.

Test Plan:
- ADD, A=9, B=8, start at edge k -> done at k+1, result 1, carry 1, overflow 1, zero 0; then SUB A=3, B=5 -> result 14, carry 1, overflow 0.
- MUL, A=5, B=3 -> busy for 4 cycles, done pulse at k+4, result 15, overflow 0; MUL A=6, B=3 -> result 2, overflow 1.
- DIV (ALU_DIV_EN), A=13, B=4 -> done at k+4, result 3, err 0; A=7, B=0 -> done at k+1, result 15, err 1. Without the macro, A=13, B=4 -> done at k+1, result 0, err 1.
- Start a MUL, then pulse start with op=ADD and new operands on cycle 2 -> ignored; MUL result 15 delivered with exactly one done pulse.
- Deassert rst_n mid-MUL on cycle 2 -> all outputs 0 immediately; no done after release; a following XOR A=10, B=10 -> result 0, zero 1.
- SHL, A=12 -> result 8, carry 1; then no start for 5 cycles -> data_result stays 8 and done stays 0.
